// File: rtl/serial_rx_frame_ctrl_if.sv
// rtl/serial_rx_frame_ctrl_if.sv - byte-in / payload-out / status bundle for serial_rx_frame_ctrl
interface serial_rx_frame_ctrl_if;
    logic [7:0] rx_data_i;
    logic       rx_ready_i;
    logic [7:0] pay_data_o;
    logic       pay_valid_o;
    logic       pay_ready_i;
    logic       pay_last_o;
    logic       frame_ok_o;
    logic       frame_err_o;
    logic [1:0] err_code_o;

    modport master (
        input  rx_data_i, rx_ready_i, pay_ready_i,
        output pay_data_o, pay_valid_o, pay_last_o, frame_ok_o, frame_err_o, err_code_o
    );

    modport slave (
        output rx_data_i, rx_ready_i, pay_ready_i,
        input  pay_data_o, pay_valid_o, pay_last_o, frame_ok_o, frame_err_o, err_code_o
    );
endinterface

// File: rtl/serial_rx_frame_ctrl.sv
// rtl/serial_rx_frame_ctrl.sv - SOF/LEN/payload framer with buffered release; SERIAL_RX_FRAME_CSUM_EN adds the XOR CSUM byte
module serial_rx_frame_ctrl #(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SOF            = 8'hAA,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic                   sysclk,
    input  logic                   reset_n,
    serial_rx_frame_ctrl_if.master bus
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LEN     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
`ifdef SERIAL_RX_FRAME_CSUM_EN
    localparam logic [2:0] ST_CSUM    = 3'd3;
`endif
    localparam logic [2:0] ST_DRAIN   = 3'd4;

    localparam int         IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         TW        = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state;
    logic [7:0]    len;
    logic [7:0]    wr_idx;
    logic [7:0]    rd_idx;
    logic [TW-1:0] tmo_cnt;
    logic          frame_ok;
    logic          frame_err;
    logic [1:0]    err_code;
    logic          counting;
    logic          tmo_hit;
    logic          pay_valid;
`ifdef SERIAL_RX_FRAME_CSUM_EN
    logic [7:0]    xor_acc;
`endif

    // Payload storage is deliberately left out of reset and error recovery.
    logic [7:0] buf_mem [0:(1<<IW)-1];

    assign counting  = (state == ST_LEN) || (state == ST_PAYLOAD)
`ifdef SERIAL_RX_FRAME_CSUM_EN
                       || (state == ST_CSUM)
`endif
                       ;
    // A byte arriving in the expiry cycle wins over the timeout.
    assign tmo_hit   = counting && !bus.rx_ready_i && (tmo_cnt == TMO_LAST);
    assign pay_valid = (state == ST_DRAIN);

    always_ff @(posedge sysclk) begin
        if (state == ST_PAYLOAD && bus.rx_ready_i)
            buf_mem[wr_idx[IW-1:0]] <= bus.rx_data_i;
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            len       <= 8'd0;
            wr_idx    <= 8'd0;
            rd_idx    <= 8'd0;
            tmo_cnt   <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
`ifdef SERIAL_RX_FRAME_CSUM_EN
            xor_acc   <= 8'd0;
`endif
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            if (bus.rx_ready_i)
                tmo_cnt <= '0;
            else if (counting && tmo_cnt != '1)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (tmo_hit) begin
                frame_err <= 1'b1;
                err_code  <= 2'b11;
                state     <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.rx_ready_i && bus.rx_data_i == SOF)
                            state <= ST_LEN;
                    end
                    ST_LEN: begin
                        if (bus.rx_ready_i) begin
                            if (bus.rx_data_i == 8'd0 || bus.rx_data_i > MAX_LEN_B) begin
                                frame_err <= 1'b1;
                                err_code  <= 2'b01;
                                state     <= ST_IDLE;
                            end else begin
                                len    <= bus.rx_data_i;
                                wr_idx <= 8'd0;
`ifdef SERIAL_RX_FRAME_CSUM_EN
                                xor_acc <= bus.rx_data_i;
`endif
                                state  <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (bus.rx_ready_i) begin
                            wr_idx <= wr_idx + 8'd1;
`ifdef SERIAL_RX_FRAME_CSUM_EN
                            xor_acc <= xor_acc ^ bus.rx_data_i;
                            if (wr_idx == len - 8'd1)
                                state <= ST_CSUM;
`else
                            if (wr_idx == len - 8'd1) begin
                                frame_ok <= 1'b1;
                                rd_idx   <= 8'd0;
                                state    <= ST_DRAIN;
                            end
`endif
                        end
                    end
`ifdef SERIAL_RX_FRAME_CSUM_EN
                    ST_CSUM: begin
                        if (bus.rx_ready_i) begin
                            if (bus.rx_data_i == xor_acc) begin
                                frame_ok <= 1'b1;
                                rd_idx   <= 8'd0;
                                state    <= ST_DRAIN;
                            end else begin
                                frame_err <= 1'b1;
                                err_code  <= 2'b10;
                                state     <= ST_IDLE;
                            end
                        end
                    end
`endif
                    ST_DRAIN: begin
                        // Bytes arriving while the buffer drains are overruns; draining continues.
                        if (bus.rx_ready_i) begin
                            frame_err <= 1'b1;
                            err_code  <= 2'b00;
                        end
                        if (bus.pay_ready_i) begin
                            rd_idx <= rd_idx + 8'd1;
                            if (rd_idx == len - 8'd1)
                                state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.pay_valid_o = pay_valid;
    assign bus.pay_data_o  = pay_valid ? buf_mem[rd_idx[IW-1:0]] : 8'h00;
    assign bus.pay_last_o  = pay_valid && (rd_idx == len - 8'd1);
    assign bus.frame_ok_o  = frame_ok;
    assign bus.frame_err_o = frame_err;
    assign bus.err_code_o  = err_code;
endmodule

// File: tb/tb_serial_rx_frame_ctrl.sv
// tb/tb_serial_rx_frame_ctrl.sv - scoreboard bench for serial_rx_frame_ctrl (both SERIAL_RX_FRAME_CSUM_EN builds)
module tb_serial_rx_frame_ctrl;
    localparam int TMO = 200;

    typedef logic [7:0] bq_t [$];

    logic sysclk;
    logic reset_n;
    int   n_vec;
    int   n_fail;

    logic [8:0] pay_q [$];
    logic [1:0] err_q [$];
    int         ok_cnt;

    serial_rx_frame_ctrl_if bus();

    serial_rx_frame_ctrl #(
        .MAX_LEN(16),
        .SOF(8'hAA),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .sysclk (sysclk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Monitor: pops the expectation queues whenever the DUT presents something.
    always @(negedge sysclk) begin
        if (reset_n) begin
            if (bus.frame_err_o) begin
                n_vec++;
                if (err_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_err: got code %0d, required no error", bus.err_code_o);
                end else begin
                    logic [1:0] e;
                    e = err_q.pop_front();
                    if (bus.err_code_o !== e) begin
                        n_fail++;
                        $display("FAIL err_code: got %0d, required %0d", bus.err_code_o, e);
                    end
                end
            end
            if (bus.frame_ok_o) begin
                n_vec++;
                if (ok_cnt == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ok: got frame_ok=1, required 0");
                end else begin
                    ok_cnt--;
                end
            end
            if (bus.pay_valid_o && bus.pay_ready_i) begin
                n_vec++;
                if (pay_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pay: got data %02h last %0b, required nothing",
                             bus.pay_data_o, bus.pay_last_o);
                end else begin
                    logic [8:0] p;
                    p = pay_q.pop_front();
                    if ({bus.pay_last_o, bus.pay_data_o} !== p) begin
                        n_fail++;
                        $display("FAIL payload: got last=%0b data=%02h, required last=%0b data=%02h",
                                 bus.pay_last_o, bus.pay_data_o, p[8], p[7:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic send_b(input logic [7:0] b);
        bus.rx_data_i  = b;
        bus.rx_ready_i = 1'b1;
        tick();
        bus.rx_ready_i = 1'b0;
        tick();
    endtask

    task automatic send_frame(input bq_t pl, input logic [7:0] cs);
        ok_cnt++;
        for (int i = 0; i < pl.size(); i++)
            pay_q.push_back({(i == pl.size() - 1), pl[i]});
        send_b(8'hAA);
        send_b(8'(pl.size()));
        for (int i = 0; i < pl.size(); i++)
            send_b(pl[i]);
`ifdef SERIAL_RX_FRAME_CSUM_EN
        send_b(cs);
`else
        if (cs === 8'hxx) tick();
`endif
    endtask

    task automatic wait_idle(input string name, input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            if (pay_q.size() == 0 && err_q.size() == 0 && ok_cnt == 0) break;
            tick();
        end
        tick();
        n_vec++;
        if (pay_q.size() != 0 || err_q.size() != 0 || ok_cnt != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d pay/%0d err/%0d ok still pending, required 0", name,
                     pay_q.size(), err_q.size(), ok_cnt);
        end
    endtask

    task automatic wait_ok(input string name, input int limit);
        for (int i = 0; i < limit && ok_cnt != 0; i++) tick();
        n_vec++;
        if (ok_cnt != 0) begin
            n_fail++;
            $display("FAIL %s: got no frame_ok, required one", name);
        end
    endtask

    task automatic chk_reset_outs(input string name);
        n_vec++;
        if (bus.pay_data_o !== 8'h00 || bus.pay_valid_o !== 1'b0 || bus.pay_last_o !== 1'b0 ||
            bus.frame_ok_o !== 1'b0 || bus.frame_err_o !== 1'b0 || bus.err_code_o !== 2'b00) begin
            n_fail++;
            $display("FAIL %s: got data=%02h valid=%0b last=%0b ok=%0b err=%0b code=%0d, required all 0",
                     name, bus.pay_data_o, bus.pay_valid_o, bus.pay_last_o,
                     bus.frame_ok_o, bus.frame_err_o, bus.err_code_o);
        end
    endtask

    initial begin
        bq_t pl;
        n_vec  = 0;
        n_fail = 0;
        ok_cnt = 0;
        reset_n        = 1'b0;
        bus.rx_data_i  = 8'h00;
        bus.rx_ready_i = 1'b0;
        bus.pay_ready_i = 1'b1;
        tick();
        tick();
        chk_reset_outs("reset_state");
        reset_n = 1'b1;
        tick();

        // Basic frame, downstream always ready; CSUM = 03^11^22^33 = 03.
        pl = {8'h11, 8'h22, 8'h33};
        send_frame(pl, 8'h03);
        wait_idle("frame_a", 40);

`ifdef SERIAL_RX_FRAME_CSUM_EN
        // 02^05^06 = 01, so FF is a checksum error.
        err_q.push_back(2'b10);
        send_b(8'hAA); send_b(8'h02); send_b(8'h05); send_b(8'h06); send_b(8'hFF);
        wait_idle("bad_csum", 20);
`endif
        pl = {8'h7E};
        send_frame(pl, 8'h7F);
        wait_idle("frame_7e", 20);

        // Illegal lengths, with a stray non-SOF byte in between that must be ignored.
        err_q.push_back(2'b01);
        send_b(8'hAA); send_b(8'h00);
        send_b(8'h3C);
        err_q.push_back(2'b01);
        send_b(8'hAA); send_b(8'h11);
        wait_idle("bad_len", 20);

        // Stall inside a frame until the timeout fires once.
        err_q.push_back(2'b11);
        send_b(8'hAA); send_b(8'h02); send_b(8'h01);
        wait_idle("timeout", TMO + 30);
        pl = {8'h5A};
        send_frame(pl, 8'h5B);
        wait_idle("frame_after_tmo", 20);

        // Async reset while a frame is waiting in DRAIN (err_code currently 11).
        bus.pay_ready_i = 1'b0;
        pl = {8'h99, 8'h88};
        send_frame(pl, 8'h13);
        wait_ok("drain_reset_ok", 20);
        tick();
        #2 reset_n = 1'b0;
        #1 chk_reset_outs("reset_in_drain");
        pay_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Overrun during DRAIN: 04^A1^B2^C3^D4 = 00.
        pl = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_frame(pl, 8'h00);
        wait_ok("overrun_ok", 20);
        err_q.push_back(2'b00);
        send_b(8'h55);
        tick(); tick(); tick();
        bus.pay_ready_i = 1'b1;
        wait_idle("overrun_drain", 30);

        // Async reset mid-PAYLOAD, then a fresh frame: 02^C0^DE = 1C.
        send_b(8'hAA); send_b(8'h03); send_b(8'h01); send_b(8'h02);
        #2 reset_n = 1'b0;
        #1 chk_reset_outs("reset_in_payload");
        tick();
        reset_n = 1'b1;
        tick();
        pl = {8'hC0, 8'hDE};
        send_frame(pl, 8'h1C);
        wait_idle("frame_after_reset", 20);

        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
